capture_reader: RTL and testbench

CAPTURE_READER -- requirements
Module: capture_reader

---
 rtl/capture_reader_pkg.sv | 22 ++
 rtl/capture_reader_if.sv | 24 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/capture_reader.sv | 150 +++++++++++++++
 tb/tb_capture_reader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_reader_pkg.sv
// Shared types and constants for the capture readout path: FSM encoding, buffer
// depth default and the address-wrap helper.
package capture_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned FifoDepthDefault = 16;
  localparam int unsigned DataW            = 16;
  localparam int unsigned AddrW            = 32;

  // Word index following idx in a ring whose highest index is last.
  function automatic logic [AddrW-1:0] next_index(input logic [AddrW-1:0] idx,
                                                  input logic [AddrW-1:0] last);
    return (idx == last) ? '0 : idx + AddrW'(1);
  endfunction

endpackage

// File: rtl/capture_reader_if.sv
// Memory read-request bus and downstream sample stream of the capture reader.
interface capture_reader_if;
  import capture_reader_pkg::*;

  logic             rd_req;
  logic [AddrW-1:0] rd_addr;
  logic             rd_ack;
  logic             rd_valid;
  logic [DataW-1:0] rd_data;
  logic             out_valid;
  logic [DataW-1:0] out_data;
  logic             out_ready;

  modport master (
    output rd_req, rd_addr, out_valid, out_data,
    input  rd_ack, rd_valid, rd_data, out_ready
  );

  modport slave (
    input  rd_req, rd_addr, out_valid, out_data,
    output rd_ack, rd_valid, rd_data, out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; simultaneous push and pop
// are accepted at every fill level.
module sync_fifo
  import capture_reader_pkg::*;
#(
  parameter int unsigned Depth = FifoDepthDefault,
  parameter int unsigned Width = DataW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    do_push = push_i & (~full_o | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/capture_reader.sv
// Reads a captured sample window out of memory as a ring of words and streams it
// downstream in address order, throttling requests to the buffer space left.
module capture_reader
  import capture_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             sample_en,
  input  logic             capture_done,
  input  logic [AddrW-1:0] sd_saddr,
  input  logic [AddrW-1:0] sample_depth,
  input  logic [AddrW-1:0] sample_last_cnt,
  output logic             read_busy,
  output logic             read_done,
  capture_reader_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  // Headroom for stale requests from aborted runs on top of live ones.
  localparam int unsigned CntW = PtrW + 3;

  state_e           state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [AddrW-1:0] remaining_q, remaining_d;
  logic             rd_req_q, rd_req_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [CntW-1:0]  discard_q, discard_d;
  logic             read_busy_q, read_busy_d;
  logic             read_done_q, read_done_d;

  logic             accept, ret, stale, push, pop, flush;
  logic [CntW-1:0]  count_d, live_d;
  logic [PtrW:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [DataW-1:0] fifo_rdata;
  logic             unused_bits;

  assign unused_bits = ^{sd_saddr[1:0], fifo_full};

  sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DataW)
  ) u_fifo (
    .clk_i   (core_clk),
    .rst_ni  (core_rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (bus.rd_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    accept        = rd_req_q & bus.rd_ack;
    ret           = bus.rd_valid & (outstanding_q != '0);
    // Returns owed to an aborted run are dropped before anything is buffered.
    stale         = ret & (discard_q != '0);
    push          = ret & ~stale & sample_en & ((state_q == StRead) | (state_q == StDrain));
    pop           = ~fifo_empty & bus.out_ready;
    flush         = 1'b0;
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(ret);
    discard_d     = discard_q - CntW'(stale);
    count_d       = CntW'(fifo_count) + CntW'(push) - CntW'(pop);
    live_d        = outstanding_d - discard_d;
    state_d       = state_q;
    ptr_d         = ptr_q;
    remaining_d   = remaining_q;

    unique case (state_q)
      StIdle: begin
        if (capture_done && sample_en) begin
          ptr_d       = {2'b00, sd_saddr[AddrW-1:2]};
          remaining_d = sample_depth;
          state_d     = (sample_depth == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (accept) begin
          ptr_d       = next_index(ptr_q, sample_last_cnt);
          remaining_d = remaining_q - AddrW'(1);
          if (remaining_q == AddrW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (live_d == '0 && count_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!sample_en) begin
      state_d     = StIdle;
      ptr_d       = '0;
      remaining_d = '0;
      flush       = 1'b1;
      discard_d   = outstanding_d;
      count_d     = '0;
      live_d      = '0;
    end

    rd_req_d    = (state_d == StRead) && (remaining_d != '0) &&
                  ((live_d + count_d) < CntW'(FIFO_DEPTH));
    read_busy_d = (state_d != StIdle);
    // Pulses the cycle after DONE is entered, as the FSM returns to IDLE.
    read_done_d = (state_q == StDone) && sample_en;
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      remaining_q   <= '0;
      rd_req_q      <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      read_busy_q   <= 1'b0;
      read_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      remaining_q   <= remaining_d;
      rd_req_q      <= rd_req_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      read_busy_q   <= read_busy_d;
      read_done_q   <= read_done_d;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = ptr_q;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_rdata;
  assign read_busy     = read_busy_q;
  assign read_done     = read_done_q;

endmodule

// File: tb/tb_capture_reader.sv
// Randomized bench for capture_reader: a behavioural memory with in-order 1..8 cycle
// latency feeds the DUT, and every handshake is scored against the expected ring walk.
module tb_capture_reader;

  localparam int unsigned Depth = 16;

  logic        core_clk;
  logic        core_rst_n;
  logic        sample_en;
  logic        capture_done;
  logic [31:0] sd_saddr;
  logic [31:0] sample_depth;
  logic [31:0] sample_last_cnt;
  logic        read_busy;
  logic        read_done;

  capture_reader_if bus ();

  capture_reader #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .core_clk        (core_clk),
    .core_rst_n      (core_rst_n),
    .sample_en       (sample_en),
    .capture_done    (capture_done),
    .sd_saddr        (sd_saddr),
    .sample_depth    (sample_depth),
    .sample_last_cnt (sample_last_cnt),
    .read_busy       (read_busy),
    .read_done       (read_done),
    .bus             (bus)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          acc_cnt, del_cnt, done_cnt, run_depth;
  int          cap_cyc, done_cyc, last_xfer_cyc;
  int          ack_rand, lat_rand, rdy_mode;
  logic [31:0] exp_addr[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;
  bit          held;
  logic [15:0] held_data;
  int          m_lat, m_due;
  logic        m_ack, m_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (lo * 16'h9e37) ^ a[31:16] ^ 16'h5a5a;
  endfunction

  // Memory responder and stream monitor; inputs for the coming edge are set here.
  always @(negedge core_clk) begin
    cyc++;
    if (!core_rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      last_due       = cyc;
      bus.rd_ack     = 1'b0;
      bus.rd_valid   = 1'b0;
      bus.rd_data    = '0;
      bus.out_ready  = 1'b0;
      held           = 1'b0;
    end else begin
      m_ack      = (ack_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rd_ack = m_ack;
      if (bus.rd_req) begin
        check_eq("req_allowed", 32'(acc_cnt < run_depth), 1);
        check_eq("credit", 32'((acc_cnt - del_cnt) < Depth), 1);
        if (m_ack) begin
          if (acc_cnt < run_depth) check_eq("rd_addr", bus.rd_addr, exp_addr[acc_cnt]);
          acc_cnt++;
          m_lat = (lat_rand != 0) ? int'($urandom_range(1, 8)) : 1;
          m_due = cyc + m_lat;
          if (m_due <= last_due) m_due = last_due + 1;
          last_due = m_due;
          pend_addr.push_back(bus.rd_addr);
          pend_due.push_back(m_due);
        end
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = 16'($urandom);
      end
      case (rdy_mode)
        0:       m_rdy = 1'b1;
        1:       m_rdy = 1'($urandom_range(0, 1));
        default: m_rdy = 1'b0;
      endcase
      bus.out_ready = m_rdy;
      if (held) begin
        check_eq("hold_valid", 32'(bus.out_valid), 1);
        check_eq("hold_data", 32'(bus.out_data), 32'(held_data));
      end
      if (bus.out_valid && m_rdy) begin
        if (del_cnt < exp_addr.size())
          check_eq("out_data", 32'(bus.out_data), 32'(mem_word(exp_addr[del_cnt])));
        else
          check_eq("extra_word", del_cnt + 1, exp_addr.size());
        del_cnt++;
        last_xfer_cyc = cyc;
      end
      held      = bus.out_valid && !m_rdy && sample_en;
      held_data = bus.out_data;
      if (read_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (capture_done && cap_cyc < 0) cap_cyc = cyc;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd_req"}, 32'(bus.rd_req), 0);
    check_eq({tag, "_rd_addr"}, bus.rd_addr, 0);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check_eq({tag, "_out_data"}, 32'(bus.out_data), 0);
    check_eq({tag, "_busy"}, 32'(read_busy), 0);
    check_eq({tag, "_done"}, 32'(read_done), 0);
  endtask

  task automatic run_case(input logic [31:0] saddr, input int depth, input logic [31:0] last,
                          input int ack_r, input int lat_r, input int rdy_m, input int stall,
                          input int abort_at, input bit do_reset, input bit double_cap);
    logic [31:0] a;
    bit          aborted;
    aborted = 1'b0;
    exp_addr.delete();
    a = {2'b00, saddr[31:2]};
    for (int i = 0; i < depth; i++) begin
      exp_addr.push_back(a);
      a = (a == last) ? 32'd0 : a + 32'd1;
    end
    run_depth     = depth;
    acc_cnt       = 0;
    del_cnt       = 0;
    done_cnt      = 0;
    cap_cyc       = -1;
    done_cyc      = -1;
    last_xfer_cyc = -1;
    ack_rand      = ack_r;
    lat_rand      = lat_r;
    rdy_mode      = rdy_m;
    sd_saddr        = saddr;
    sample_depth    = depth;
    sample_last_cnt = last;
    @(posedge core_clk); #1 capture_done = 1'b1;
    @(posedge core_clk); #1 capture_done = 1'b0;
    check_eq("busy_start", 32'(read_busy), 1);
    for (int k = 0; k < 3000 && done_cnt == 0 && !aborted; k++) begin
      if (stall > 0 && k == stall) begin
        check_eq("stall_fill", acc_cnt, Depth);
        rdy_mode = 0;
      end
      if (double_cap && k == 15) begin
        sd_saddr     = saddr + 32'h100;
        capture_done = 1'b1;
        @(posedge core_clk); #1 capture_done = 1'b0;
      end
      if (abort_at > 0 && del_cnt >= abort_at) begin
        sample_en = 1'b0;
        @(posedge core_clk); #1;
        check_eq("abort_valid", 32'(bus.out_valid), 0);
        check_eq("abort_busy", 32'(read_busy), 0);
        check_eq("abort_req", 32'(bus.rd_req), 0);
        @(posedge core_clk); #1 sample_en = 1'b1;
        aborted = 1'b1;
      end else if (do_reset && k == 20) begin
        core_rst_n = 1'b0;
        @(posedge core_clk); #1 core_rst_n = 1'b1;
        check_outputs_zero("midreset");
        aborted = 1'b1;
      end else begin
        @(posedge core_clk); #1;
      end
    end
    repeat (3) @(posedge core_clk);
    #1;
    if (aborted) begin
      check_eq("no_done", done_cnt, 0);
    end else begin
      check_eq("word_count", del_cnt, depth);
      check_eq("req_count", acc_cnt, depth);
      check_eq("done_once", done_cnt, 1);
      if (depth == 0) check_eq("done_lat0", done_cyc - cap_cyc, 2);
      else            check_eq("done_lat", done_cyc - last_xfer_cyc, 2);
      check_eq("end_idle", 32'(read_busy), 0);
    end
  endtask

  function automatic logic [31:0] rand_saddr(input int max_idx);
    return (32'($urandom_range(0, max_idx)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    core_rst_n      = 1'b0;
    sample_en       = 1'b1;
    capture_done    = 1'b0;
    sd_saddr        = '0;
    sample_depth    = '0;
    sample_last_cnt = '0;
    run_depth       = 0;
    acc_cnt         = 0;
    del_cnt         = 0;
    done_cnt        = 0;
    cap_cyc         = -1;
    ack_rand        = 0;
    lat_rand        = 0;
    rdy_mode        = 0;
    repeat (3) @(posedge core_clk);
    #1 check_outputs_zero("reset");
    core_rst_n = 1'b1;
    @(posedge core_clk); #1;

    // Ring wrap from index 6 with a fixed one-cycle memory.
    run_case(32'h18, 8, 32'd7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // Empty window goes straight to done.
    run_case(32'h40, 0, 32'd7, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // Downstream stalls for 100 cycles; requests must stop at the buffer depth.
    run_case(rand_saddr(63), 40, 32'd63, 0, 1, 2, 100, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_case(rand_saddr(31), 32, (i == 2) ? 32'd31 : 32'd63, 1, 1, 1, 0, 0, 1'b0, i == 1);
    end
    // Abort after 10 words while returns are still in flight, then a clean run.
    run_case(rand_saddr(63), 32, 32'd63, 0, 1, 0, 0, 10, 1'b0, 1'b0);
    run_case(rand_saddr(63), 32, 32'd63, 1, 1, 1, 0, 0, 1'b0, 1'b0);
    // Reset pulse mid-read, then a clean run.
    run_case(rand_saddr(63), 32, 32'd63, 0, 1, 0, 0, 0, 1'b1, 1'b0);
    run_case(rand_saddr(31), 20, 32'd31, 1, 1, 1, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
